sys_arr_ctrl: RTL
=================

# sys_arr_ctrl

Job controller for the M×M systolic matrix-multiply array. It latches a full A and B operand pair from the host and clears the array's accumulators. It then streams diagonally skewed rows of A and columns of B into the array's edge ports, captures the finished C matrix, and holds it for the host under a valid/ready handshake. It sits between the host/register interface and the array instance at the accelerator top level.

## Interface
- M, 3, square matrix dimension (M ≥ 2)
- CLK  in  1  single clock; all state on posedge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  job request; sampled only in IDLE
- a_mat  in  [7:0] × [M][M]  operand A, sampled on start acceptance
- b_mat  in  [7:0] × [M][M]  operand B, sampled on start acceptance
- busy  out  1  high in every state except IDLE
- arr_rst  out  1  active-high synchronous clear to the array
- arr_vld_in  out  1  array valid; high only in FEED
- arr_rdy_out  out  1  array downstream-ready; identical to arr_vld_in
- arr_a  out  [7:0] × [M]  A stream, one entry per array row
- arr_b  out  [7:0] × [M]  B stream, one entry per array column
- arr_c  in  [15:0] × [M][M]  array accumulator outputs
- res_c  out  [15:0] × [M][M]  captured result, stable while res_valid
- res_valid  out  1  result available
- res_ready  in  1  host accepts result

## Operation
- States: IDLE, CLEAR, FEED, CAPTURE, HOLD.
- IDLE:
  - start=1 latches a_mat/b_mat into internal A_r/B_r.
  - Then → CLEAR.
- CLEAR:
  - One cycle, arr_rst=1.
  - Then → FEED with the beat counter t=0.
- FEED:
  - RUN = 3M−2 beats, t = 0 … 3M−3; arr_vld_in = arr_rdy_out = 1.
  - arr_a[i] = A_r[i][t−i] if 0 ≤ t−i < M, else 0.
  - arr_b[j] = B_r[t−j][j] if 0 ≤ t−j < M, else 0.
  - At t = 3M−3 → CAPTURE.
- CAPTURE:
  - arr_vld_in=0, streams 0.
  - res_c ← arr_c at the end of the cycle.
  - Then → HOLD.
- HOLD:
  - res_valid=1, res_c frozen.
  - res_valid & res_ready → IDLE.
- Outside FEED, arr_a/arr_b are all zero.
- start outside IDLE is ignored. No queuing.
- start in the same cycle that HOLD completes is ignored. The controller reaches IDLE first.
- Arithmetic: the controller does no arithmetic on data. arr_c passes through unchanged; the array wraps sums modulo 2^16.
- Beat counter width: $clog2(3M−2)+1 bits. No wrap occurs within a job.
- Reset (asynchronous, any state, including mid-FEED):
  - State → IDLE, counter → 0, res_c → 0, A_r/B_r → 0.
  - Outputs: busy=0, arr_rst=1, arr_vld_in=0, arr_rdy_out=0, arr_a=0, arr_b=0, res_valid=0.
  - arr_rst stays 1 until the first clock edge after rst_n deasserts, then drops to 0 in IDLE. This guarantees the array sees at least one clocked clear.

## Timing
- Cycle 0: IDLE with start=1.
- Cycle 1: CLEAR.
- Cycles 2 … 3M−1: FEED.
- Cycle 3M: CAPTURE.
- Cycle 3M+1: HOLD, res_valid high.
- Latency from start to res_valid is 3M+1 cycles (M=3: 10).
- Minimum job period is 3M+2 cycles, with res_ready tied high.
- busy is high from cycle 1 through the cycle in which HOLD completes.
- All outputs are registered or decoded from registered state and counter. There is no combinational path from any input to any output.
- res_valid, once high, does not drop until the res_ready handshake completes or reset asserts.

## Structure
- Shared package sys_arr_pkg holds:
  - DATA_W=8 and ACC_W=16;
  - the state enum ctrl_state_t;
  - a function run_beats(M) returning 3M−2.
- One sub-module, sys_arr_skew: a combinational mux from (A_r, B_r, t, feed_en) to arr_a/arr_b.
- The controller does not instantiate the array. The accelerator top wires the two together.

## Test plan
- Identity × B, M=3: A=I, B=[[1,2,3],[4,5,6],[7,8,9]] → res_c equals B, res_valid first at cycle 10.
- Saturating operands, M=3: all entries 255 → every res_c entry = 195075 mod 65536 = 64003.
- Skew check: at FEED beat t=2 → arr_a = {A[0][2], A[1][1], A[2][0]} and arr_b = {B[2][0], B[1][1], B[0][2]}. At t=0 → only arr_a[0]/arr_b[0] are non-zero.
- Backpressure: hold res_ready=0 for 20 cycles after res_valid → res_valid and res_c stay stable, busy=1, and start pulses are ignored. Raising res_ready → IDLE next cycle and busy=0.
- Start while busy: pulse start at cycle 4 of a job → no second CLEAR, and exactly one result.
- Reset mid-FEED: assert rst_n=0 at beat t=3 → all outputs at reset values immediately. After release → arr_rst drops after one edge. A fresh job then yields the correct product, with no residue from the aborted job.

Source files
------------

// File: rtl/sys_arr_pkg.sv
// Shared types and constants for the systolic-array job controller.
package sys_arr_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_CAPTURE,
    S_HOLD
  } ctrl_state_t;

  // Beats needed to push the last skewed operand pair into PE(M-1,M-1).
  function automatic int run_beats(input int m);
    return 3 * m - 2;
  endfunction

endpackage

// File: rtl/sys_arr_ctrl_if.sv
// Host and array side signals of the controller, bundled.
// slave: controller view; master: host plus array view.
interface sys_arr_ctrl_if
  import sys_arr_pkg::*;
#(
  parameter int M = 3
);

  logic                                 start;
  logic [M-1:0][M-1:0][DATA_W-1:0]      a_mat;
  logic [M-1:0][M-1:0][DATA_W-1:0]      b_mat;
  logic                                 busy;
  logic                                 arr_rst;
  logic                                 arr_vld_in;
  logic                                 arr_rdy_out;
  logic [M-1:0][DATA_W-1:0]             arr_a;
  logic [M-1:0][DATA_W-1:0]             arr_b;
  logic [M-1:0][M-1:0][ACC_W-1:0]       arr_c;
  logic [M-1:0][M-1:0][ACC_W-1:0]       res_c;
  logic                                 res_valid;
  logic                                 res_ready;

  modport slave (
    input  start, a_mat, b_mat, arr_c, res_ready,
    output busy, arr_rst, arr_vld_in, arr_rdy_out, arr_a, arr_b, res_c, res_valid
  );

  modport master (
    output start, a_mat, b_mat, arr_c, res_ready,
    input  busy, arr_rst, arr_vld_in, arr_rdy_out, arr_a, arr_b, res_c, res_valid
  );

endinterface

// File: rtl/sys_arr_skew.sv
// Diagonal skew mux: lane l carries A[l][t-l] and B[t-l][l] while feeding.
module sys_arr_skew
  import sys_arr_pkg::*;
#(
  parameter int M     = 3,
  parameter int CNT_W = 4
) (
  input  logic [M-1:0][M-1:0][DATA_W-1:0] a_r,
  input  logic [M-1:0][M-1:0][DATA_W-1:0] b_r,
  input  logic [CNT_W-1:0]                t,
  input  logic                            feed_en,
  output logic [M-1:0][DATA_W-1:0]        arr_a,
  output logic [M-1:0][DATA_W-1:0]        arr_b
);

  for (genvar l = 0; l < M; l++) begin : g_lane
    logic [DATA_W-1:0] a_l;
    logic [DATA_W-1:0] b_l;

    // Pick the k with t == l + k; lanes outside their window stay zero.
    always_comb begin
      a_l = '0;
      b_l = '0;
      for (int k = 0; k < M; k++) begin
        if (feed_en && (t == CNT_W'(l + k))) begin
          a_l = a_r[l][k];
          b_l = b_r[k][l];
        end
      end
    end

    assign arr_a[l] = a_l;
    assign arr_b[l] = b_l;
  end

endmodule

// File: rtl/sys_arr_ctrl.sv
// Job controller for the MxM systolic array: latch operands, clear,
// stream skewed operands, capture C, hold it for the host.
module sys_arr_ctrl
  import sys_arr_pkg::*;
#(
  parameter int M = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  sys_arr_ctrl_if.slave bus
);

  localparam int RUN   = run_beats(M);
  localparam int CNT_W = $clog2(RUN) + 1;

  typedef logic [M-1:0][M-1:0][DATA_W-1:0] opmat_t;
  typedef logic [M-1:0][M-1:0][ACC_W-1:0]  accmat_t;

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  opmat_t           a_q, a_d;
  opmat_t           b_q, b_d;
  accmat_t          res_c_q, res_c_d;
  logic             busy_q, busy_d;
  logic             arr_rst_q, arr_rst_d;
  logic             feed_q, feed_d;
  logic             res_valid_q, res_valid_d;

  // Next state; status outputs are decoded from the next state so they
  // come straight out of flops and line up with the state they describe.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    res_c_d = res_c_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a_mat;
          b_d     = bus.b_mat;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        t_d     = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        if (t_q == CNT_W'(RUN - 1)) begin
          t_d     = '0;
          state_d = S_CAPTURE;
        end else begin
          t_d = t_q + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        res_c_d = bus.arr_c;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // A start seen here is dropped: the handshake only returns to IDLE.
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d      = (state_d != S_IDLE);
    arr_rst_d   = (state_d == S_CLEAR);
    feed_d      = (state_d == S_FEED);
    res_valid_d = (state_d == S_HOLD);
  end

  // State, counter, operand/result registers and registered outputs.
  // arr_rst resets high so the array is held clear until the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      t_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_c_q     <= '0;
      busy_q      <= 1'b0;
      arr_rst_q   <= 1'b1;
      feed_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_c_q     <= res_c_d;
      busy_q      <= busy_d;
      arr_rst_q   <= arr_rst_d;
      feed_q      <= feed_d;
      res_valid_q <= res_valid_d;
    end
  end

  sys_arr_skew #(
    .M     (M),
    .CNT_W (CNT_W)
  ) u_skew (
    .a_r     (a_q),
    .b_r     (b_q),
    .t       (t_q),
    .feed_en (feed_q),
    .arr_a   (bus.arr_a),
    .arr_b   (bus.arr_b)
  );

  assign bus.busy        = busy_q;
  assign bus.arr_rst     = arr_rst_q;
  assign bus.arr_vld_in  = feed_q;
  assign bus.arr_rdy_out = feed_q;
  assign bus.res_c       = res_c_q;
  assign bus.res_valid   = res_valid_q;

endmodule
